thresh_bank: RTL and testbench
==============================

THRESH_BANK -- requirements
Module: thresh_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of threshold channels (1..16).
REQ-002 Parameter WIDTH, default 24, bits per threshold (1..32).
REQ-003 Parameter ADDR_W, default 3, slave address width, SHALL be >= clog2(NUM_CH+2).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 address  in  ADDR_W  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data; bits above WIDTH ignored for threshold words.
REQ-010 readdata  out  32  combinational read data, zero-extended.
REQ-011 frame_sync  in  1  single-cycle pulse marking an acquisition frame boundary.
REQ-012 out_port  out  NUM_CH*WIDTH  active thresholds, channel 0 in bits [WIDTH-1:0].
REQ-013 irq  out  1  commit-done interrupt (present only per REQ-030).

Function
REQ-014 Write = chipselect high and write_n low in one cycle; address decode per REQ-015..017.
REQ-015 Addresses 0..NUM_CH-1 SHALL write the channel shadow register with writedata[WIDTH-1:0].
REQ-016 Address NUM_CH (CTRL) SHALL be write-only: bit0 COMMIT arms a frame-synchronous commit, bit1 NOW requests an immediate commit; reads return 0.
REQ-017 Address NUM_CH+1 (STATUS) SHALL read bit0 PENDING, bit1 DONE; writing 1 to bit1 clears DONE.
REQ-018 Reads of shadow addresses SHALL return the shadow value; unmapped addresses SHALL read 0; read latency 0.
REQ-019 State machine IDLE/ARMED: COMMIT write in IDLE -> ARMED (PENDING=1); first frame_sync seen in ARMED -> copy all shadows to active on that edge, -> IDLE, DONE set.
REQ-020 frame_sync coincident with the COMMIT write SHALL NOT apply it; the next frame_sync applies it.
REQ-021 NOW write SHALL copy all shadows to active on the following clock edge from either state, return to IDLE, set DONE.
REQ-022 COMMIT and NOW in the same write SHALL act as NOW only.
REQ-023 COMMIT while ARMED SHALL have no effect (stays ARMED).
REQ-024 Shadow write in the same cycle as a copy SHALL be stored in shadow but the copy SHALL use the pre-write shadow value.
REQ-025 Shadow writes while ARMED are accepted and included in the pending copy.
REQ-026 All channels SHALL update in the same cycle; out_port never shows a partial set.
REQ-027 DONE set and W1C clear in the same cycle: set wins.

Reset
REQ-028 On reset_n low: all shadow and active registers 0, out_port 0, state IDLE, PENDING 0, DONE 0, irq 0; reset mid-ARMED discards the pending commit.

Configuration
REQ-029 Macro THRESH_BANK_IRQ_EN selects the interrupt feature.
REQ-030 Defined: irq = DONE, registered, held until cleared via STATUS. Undefined: irq port tied 0, DONE still readable.

Structure
REQ-031 Package thresh_bank_pkg SHALL hold CTRL/STATUS offsets relative to NUM_CH, control/status bit positions and the state enum.
REQ-032 Sub-module thresh_bank_chan SHALL hold one shadow/active pair with load and copy enables; instantiated NUM_CH times.

Verification
REQ-033 Write 0x123456 to ch0, COMMIT, frame_sync after 5 cycles -> out_port[23:0] stays 0 until that edge, then 0x123456; PENDING 1->0, DONE=1.
REQ-034 COMMIT write coincident with frame_sync -> no update; next frame_sync applies.
REQ-035 Write ch1=0xABCDEF, NOW -> out_port[47:24]=0xABCDEF one edge later, no frame_sync needed.
REQ-036 Shadow ch2 write on copy edge -> active ch2 holds old value, shadow read returns new value.
REQ-037 With THRESH_BANK_IRQ_EN: commit -> irq=1; W1C STATUS bit1 -> irq=0; reset while ARMED -> PENDING=0, out_port=0.

Source files
------------

// File: rtl/thresh_bank_pkg.sv
// rtl/thresh_bank_pkg.sv - Register map offsets, control/status bit positions and FSM states for thresh_bank
package thresh_bank_pkg;

  // CTRL and STATUS sit directly after the NUM_CH shadow words
  localparam int CTRL_OFS   = 0;
  localparam int STATUS_OFS = 1;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_NOW_BIT    = 1;

  localparam int STAT_PENDING_BIT = 0;
  localparam int STAT_DONE_BIT    = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/thresh_bank_chan.sv
// rtl/thresh_bank_chan.sv - One shadow/active threshold pair with independent load and copy enables
module thresh_bank_chan #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             copy_en,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] active
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;

  // copy reads shadow_q, so a load on the copy edge lands only in the shadow
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (load_en) begin
      shadow_d = load_data;
    end
    if (copy_en) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow = shadow_q;
  assign active = active_q;

endmodule

// File: rtl/thresh_bank.sv
// rtl/thresh_bank.sv - Threshold bank with shadow registers and frame-synchronous or immediate commit
// Define THRESH_BANK_IRQ_EN to drive irq from the DONE flag; otherwise irq is tied low.
module thresh_bank
  import thresh_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic                    frame_sync,
  output logic [NUM_CH*WIDTH-1:0] out_port,
  output logic                    irq
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_CH + CTRL_OFS);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_CH + STATUS_OFS);

  state_t     state_q, state_d;
  logic       done_q, done_d;
  logic       wr_en;
  logic       ctrl_wr;
  logic       status_wr;
  logic       now_req;
  logic       commit_req;
  logic       copy_en;
  logic       pending;
  logic [WIDTH-1:0] shadow [NUM_CH];
  logic       unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign ctrl_wr   = wr_en && (address == CTRL_ADDR);
  assign status_wr = wr_en && (address == STATUS_ADDR);

  // NOW dominates COMMIT when both bits are written together
  assign now_req    = ctrl_wr && writedata[CTRL_NOW_BIT];
  assign commit_req = ctrl_wr && writedata[CTRL_COMMIT_BIT] && !writedata[CTRL_NOW_BIT];
  assign copy_en    = now_req || ((state_q == ST_ARMED) && frame_sync);
  assign pending    = (state_q == ST_ARMED);

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    if (copy_en) begin
      state_d = ST_IDLE;
    end else if (commit_req && (state_q == ST_IDLE)) begin
      state_d = ST_ARMED;
    end
    // a copy on the same edge as a W1C leaves DONE set
    if (copy_en) begin
      done_d = 1'b1;
    end else if (status_wr && writedata[STAT_DONE_BIT]) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    thresh_bank_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_en  (wr_en && (address == ADDR_W'(i))),
      .load_data(writedata[WIDTH-1:0]),
      .copy_en  (copy_en),
      .shadow   (shadow[i]),
      .active   (out_port[i*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    readdata = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (address == ADDR_W'(i)) begin
        readdata = 32'(shadow[i]);
      end
    end
    if (address == STATUS_ADDR) begin
      readdata[STAT_PENDING_BIT] = pending;
      readdata[STAT_DONE_BIT]    = done_q;
    end
  end

`ifdef THRESH_BANK_IRQ_EN
  assign irq = done_q;
`else
  assign irq = 1'b0;
`endif

  assign unused_wdata = &{1'b0, writedata};

endmodule

// File: tb/tb_thresh_bank.sv
// tb/tb_thresh_bank.sv - Self-checking bench for thresh_bank: directed vector table plus randomized model comparison
module tb_thresh_bank;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 24;
  localparam int ADDR_W = 3;

  logic                    clk;
  logic                    reset_n;
  logic [ADDR_W-1:0]       address;
  logic                    chipselect;
  logic                    write_n;
  logic [31:0]             writedata;
  logic [31:0]             readdata;
  logic                    frame_sync;
  logic [NUM_CH*WIDTH-1:0] out_port;
  logic                    irq;

  int tests;
  int fails;

  logic [WIDTH-1:0] sh_m  [NUM_CH];
  logic [WIDTH-1:0] act_m [NUM_CH];
  bit pend_m;
  bit done_m;

  typedef struct {
    bit                      wr;
    logic [ADDR_W-1:0]       addr;
    logic [31:0]             wd;
    bit                      fs;
    logic [NUM_CH*WIDTH-1:0] exp_out;
    logic [1:0]              exp_stat;
  } vec_t;

  vec_t vecs [23];

  thresh_bank #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .frame_sync(frame_sync),
    .out_port  (out_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [NUM_CH*WIDTH-1:0] pk(input logic [23:0] c3, input logic [23:0] c2,
                                                  input logic [23:0] c1, input logic [23:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [NUM_CH*WIDTH-1:0] model_out();
    logic [NUM_CH*WIDTH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*WIDTH +: WIDTH] = act_m[i];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a < NUM_CH) return {8'd0, sh_m[a]};
    if (a == NUM_CH + 1) return {30'd0, done_m, pend_m};
    return 32'd0;
  endfunction

  function automatic bit model_irq();
`ifdef THRESH_BANK_IRQ_EN
    return done_m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      sh_m[i]  = '0;
      act_m[i] = '0;
    end
    pend_m = 0;
    done_m = 0;
  endtask

  // Applies the register-level rules to the model, then clocks the DUT with the same inputs
  task automatic cycle(input bit cs, input bit wn, input int addr, input logic [31:0] wd, input bit fs);
    bit wr;
    bit copy;
    wr = cs && !wn;
    copy = (wr && addr == NUM_CH && wd[1]) || (pend_m && fs);
    if (copy) begin
      for (int i = 0; i < NUM_CH; i++) act_m[i] = sh_m[i];
      pend_m = 0;
      done_m = 1;
    end else begin
      if (wr && addr == NUM_CH && wd[0]) pend_m = 1;
      if (wr && addr == NUM_CH + 1 && wd[1]) done_m = 0;
    end
    if (wr && addr < NUM_CH) sh_m[addr] = wd[WIDTH-1:0];
    address    = ADDR_W'(addr);
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    frame_sync = fs;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    frame_sync = 1'b0;
  endtask

  task automatic read_status(output logic [1:0] st);
    address = ADDR_W'(NUM_CH + 1);
    #1;
    st = readdata[1:0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out"}, 128'(out_port), 128'(model_out()));
    chk({tag, "_irq"}, 128'(irq), 128'(model_irq()));
    for (int a = 0; a < 8; a++) begin
      address = ADDR_W'(a);
      #1;
      chk($sformatf("%s_rd%0d", tag, a), 128'(readdata), 128'(model_read(a)));
    end
  endtask

  initial begin
    logic [1:0] st;
    tests = 0;
    fails = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    frame_sync = 1'b0;
    model_reset();

    vecs[0]  = '{1, 3'd0, 32'h0012_3456, 0, pk(0, 0, 0, 0), 2'b00};
    vecs[1]  = '{1, 3'd4, 32'h1,         0, pk(0, 0, 0, 0), 2'b01};
    vecs[2]  = '{0, 3'd0, 32'h0,         0, pk(0, 0, 0, 0), 2'b01};
    vecs[3]  = '{0, 3'd0, 32'h0,         0, pk(0, 0, 0, 0), 2'b01};
    vecs[4]  = '{0, 3'd0, 32'h0,         0, pk(0, 0, 0, 0), 2'b01};
    vecs[5]  = '{0, 3'd0, 32'h0,         0, pk(0, 0, 0, 0), 2'b01};
    vecs[6]  = '{0, 3'd0, 32'h0,         1, pk(0, 0, 0, 24'h123456), 2'b10};
    vecs[7]  = '{1, 3'd5, 32'h2,         0, pk(0, 0, 0, 24'h123456), 2'b00};
    vecs[8]  = '{1, 3'd0, 32'h0011_1111, 0, pk(0, 0, 0, 24'h123456), 2'b00};
    vecs[9]  = '{1, 3'd4, 32'h1,         1, pk(0, 0, 0, 24'h123456), 2'b01};
    vecs[10] = '{0, 3'd0, 32'h0,         0, pk(0, 0, 0, 24'h123456), 2'b01};
    vecs[11] = '{0, 3'd0, 32'h0,         1, pk(0, 0, 0, 24'h111111), 2'b10};
    vecs[12] = '{1, 3'd1, 32'h00AB_CDEF, 0, pk(0, 0, 0, 24'h111111), 2'b10};
    vecs[13] = '{1, 3'd4, 32'h2,         0, pk(0, 0, 24'hABCDEF, 24'h111111), 2'b10};
    vecs[14] = '{1, 3'd2, 32'h0022_2222, 0, pk(0, 0, 24'hABCDEF, 24'h111111), 2'b10};
    vecs[15] = '{1, 3'd4, 32'h1,         0, pk(0, 0, 24'hABCDEF, 24'h111111), 2'b11};
    vecs[16] = '{1, 3'd2, 32'h0033_3333, 1, pk(0, 24'h222222, 24'hABCDEF, 24'h111111), 2'b10};
    vecs[17] = '{1, 3'd4, 32'h3,         0, pk(0, 24'h333333, 24'hABCDEF, 24'h111111), 2'b10};
    vecs[18] = '{1, 3'd4, 32'h1,         0, pk(0, 24'h333333, 24'hABCDEF, 24'h111111), 2'b11};
    vecs[19] = '{1, 3'd4, 32'h1,         0, pk(0, 24'h333333, 24'hABCDEF, 24'h111111), 2'b11};
    vecs[20] = '{1, 3'd5, 32'h2,         1, pk(0, 24'h333333, 24'hABCDEF, 24'h111111), 2'b10};
    vecs[21] = '{1, 3'd3, 32'hFF44_5566, 0, pk(0, 24'h333333, 24'hABCDEF, 24'h111111), 2'b10};
    vecs[22] = '{1, 3'd4, 32'h2,         0, pk(24'h445566, 24'h333333, 24'hABCDEF, 24'h111111), 2'b10};

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 23; v++) begin
      cycle(vecs[v].wr, !vecs[v].wr, int'(vecs[v].addr), vecs[v].wd, vecs[v].fs);
      chk($sformatf("vec%0d_out", v), 128'(out_port), 128'(vecs[v].exp_out));
      read_status(st);
      chk($sformatf("vec%0d_stat", v), 128'(st), 128'(vecs[v].exp_stat));
    end
    address = 3'd2;
    #1;
    chk("shadow2_after_copy_edge", 128'(readdata), 128'(32'h0033_3333));
    check_all("table_end");

    // Irq raise and W1C clear
    cycle(1, 0, NUM_CH + 1, 32'h2, 0);
    cycle(1, 0, NUM_CH, 32'h2, 0);
    chk("irq_after_now", 128'(irq), 128'(model_irq()));
    cycle(1, 0, NUM_CH + 1, 32'h2, 0);
    chk("irq_after_w1c", 128'(irq), 128'(1'b0));

    for (int n = 0; n < 400; n++) begin
      bit cs, wn, fs;
      int a;
      logic [31:0] wd;
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, 7);
      wd = $urandom();
      if (a >= NUM_CH && $urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 3));
      fs = ($urandom_range(0, 7) == 0);
      cycle(cs, wn, a, wd, fs);
      chk($sformatf("rnd%0d_out", n), 128'(out_port), 128'(model_out()));
      read_status(st);
      chk($sformatf("rnd%0d_stat", n), 128'(st), 128'({done_m, pend_m}));
      chk($sformatf("rnd%0d_irq", n), 128'(irq), 128'(model_irq()));
      if (n % 25 == 0) check_all($sformatf("rnd%0d", n));
    end

    // Reset while armed discards the pending commit
    cycle(1, 0, 0, 32'h0055_AA55, 0);
    cycle(1, 0, NUM_CH, 32'h2, 0);
    cycle(1, 0, 0, 32'h0077_7777, 0);
    cycle(1, 0, NUM_CH, 32'h1, 0);
    read_status(st);
    chk("armed_before_reset", 128'(st), 128'(2'b11));
    #2;
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("async_reset_out", 128'(out_port), 128'(0));
    check_all("in_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(0, 1, 0, 32'h0, 1);
    check_all("post_reset_fs");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
